execute_stage: RTL and testbench

- EX stage of the 5-stage MIPS pipeline: forwarding select, operand muxing, ALU, branch resolution and the EX/MEM pipeline register.
- Sits between the ID/EX register and the MEM stage.
- Outputs the combinational destination register to the hazard unit and the branch decision/target to fetch.

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/forward_unit.sv | 36 +++
 rtl/execute_stage.sv | 125 ++++++++++++
 tb/tb_execute_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the MIPS pipeline.
//   ALU operation classes, R-type function codes, forwarding-select and
//   branch encodings used by the EX stage and its forwarding unit.
package mips_pkg;

   // ALU operation classes driven by the decoder
   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_AND   = 4'b0010;
   localparam logic [3:0] ALU_OR    = 4'b0011;
   localparam logic [3:0] ALU_SLT   = 4'b0100;
   localparam logic [3:0] ALU_RTYPE = 4'b0101;
   localparam logic [3:0] ALU_XOR   = 4'b0110;
   localparam logic [3:0] ALU_LUI   = 4'b0111;

   // R-type function field
   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_XOR = 6'b100110;
   localparam logic [5:0] FN_NOR = 6'b100111;
   localparam logic [5:0] FN_SLT = 6'b101010;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_WB    = 2'b01,
      FWD_EXMEM = 2'b10
   } fwd_sel_e;

   typedef enum logic [1:0] {
      BR_NONE  = 2'b00,
      BR_BEQ   = 2'b01,
      BR_BNE   = 2'b10,
      BR_NONE3 = 2'b11
   } branch_e;

endpackage

// File: rtl/forward_unit.sv
// forward_unit: combinational forwarding select for the two EX source operands.
//   ex_reg_write_i/ex_reg_addr_i       : EX/MEM destination and write enable
//   memwb_reg_write_i/memwb_reg_addr_i : MEM/WB destination and write enable
//   rs_addr_i/rt_addr_i                : source register addresses in EX
//   fwd_a_o/fwd_b_o                    : operand select for rs / rt
module forward_unit
   import mips_pkg::*;
(
   input  logic     ex_reg_write_i,
   input  logic [4:0] ex_reg_addr_i,
   input  logic     memwb_reg_write_i,
   input  logic [4:0] memwb_reg_addr_i,
   input  logic [4:0] rs_addr_i,
   input  logic [4:0] rt_addr_i,
   output fwd_sel_e fwd_a_o,
   output fwd_sel_e fwd_b_o
);

   // EX/MEM wins over MEM/WB; register 0 is hardwired and never forwarded
   function automatic fwd_sel_e sel_for(input logic [4:0] src);
      if (ex_reg_write_i && (ex_reg_addr_i != 5'd0) && (ex_reg_addr_i == src)) begin
         return FWD_EXMEM;
      end else if (memwb_reg_write_i && (memwb_reg_addr_i != 5'd0)
                   && (memwb_reg_addr_i == src)) begin
         return FWD_WB;
      end else begin
         return FWD_RF;
      end
   endfunction

   always_comb begin
      fwd_a_o = sel_for(rs_addr_i);
      fwd_b_o = sel_for(rt_addr_i);
   end

endmodule

// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 5-stage MIPS pipeline.
//   Inputs : ID/EX control and operands, MEM/WB write-back info, clk/reset.
//   Outputs: dest_addr (to hazard unit), branch_taken/pc_branch (to fetch),
//            exmem_* (registered EX/MEM pipeline register).
module execute_stage
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_incremented,
   input  logic        mem_to_reg_in,
   input  logic        reg_write_in,
   input  logic        mem_write_in,
   input  logic        mem_read_in,
   input  logic [3:0]  alu_op,
   input  logic        alu_src,
   input  logic        reg_dst,
   input  logic [1:0]  branch,
   input  logic [31:0] imm_ext,
   input  logic [4:0]  rs_addr,
   input  logic [4:0]  rt_addr,
   input  logic [4:0]  rd_addr,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic [5:0]  func,
   input  logic        memwb_reg_write,
   input  logic [4:0]  memwb_reg_addr,
   input  logic [31:0] wb_data,
   output logic [4:0]  dest_addr,
   output logic        branch_taken,
   output logic [31:0] pc_branch,
   output logic        exmem_mem_to_reg,
   output logic        exmem_reg_write,
   output logic        exmem_mem_write,
   output logic        exmem_mem_read,
   output logic [31:0] exmem_alu_result,
   output logic [31:0] exmem_store_data,
   output logic [4:0]  exmem_reg_addr
);

   fwd_sel_e    fwd_a, fwd_b;
   logic [31:0] op_a, fwd_rt, op_b, alu_res;
   logic        zero;

   forward_unit u_forward_unit (
      .ex_reg_write_i    (exmem_reg_write),
      .ex_reg_addr_i     (exmem_reg_addr),
      .memwb_reg_write_i (memwb_reg_write),
      .memwb_reg_addr_i  (memwb_reg_addr),
      .rs_addr_i         (rs_addr),
      .rt_addr_i         (rt_addr),
      .fwd_a_o           (fwd_a),
      .fwd_b_o           (fwd_b)
   );

   always_comb begin
      case (fwd_a)
         FWD_EXMEM: op_a = exmem_alu_result;
         FWD_WB:    op_a = wb_data;
         default:   op_a = rs_data;
      endcase
      case (fwd_b)
         FWD_EXMEM: fwd_rt = exmem_alu_result;
         FWD_WB:    fwd_rt = wb_data;
         default:   fwd_rt = rt_data;
      endcase
      op_b = alu_src ? imm_ext : fwd_rt;
   end

   always_comb begin
      alu_res = 32'd0;
      case (alu_op)
         ALU_ADD: alu_res = op_a + op_b;
         ALU_SUB: alu_res = op_a - op_b;
         ALU_AND: alu_res = op_a & op_b;
         ALU_OR:  alu_res = op_a | op_b;
         ALU_SLT: alu_res = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
         ALU_XOR: alu_res = op_a ^ op_b;
         ALU_LUI: alu_res = {op_b[15:0], 16'd0};
         ALU_RTYPE: begin
            case (func)
               FN_ADD:  alu_res = op_a + op_b;
               FN_SUB:  alu_res = op_a - op_b;
               FN_AND:  alu_res = op_a & op_b;
               FN_OR:   alu_res = op_a | op_b;
               FN_XOR:  alu_res = op_a ^ op_b;
               FN_NOR:  alu_res = ~(op_a | op_b);
               FN_SLT:  alu_res = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
               // shamt lives in imm_ext[10:6]; shifts always act on rt
               FN_SLL:  alu_res = fwd_rt << imm_ext[10:6];
               FN_SRL:  alu_res = fwd_rt >> imm_ext[10:6];
               default: alu_res = 32'd0;
            endcase
         end
         default: alu_res = 32'd0;
      endcase
   end

   // Branch compare uses forwarded rt, independent of alu_src
   assign zero         = (op_a == fwd_rt);
   assign branch_taken = ((branch == BR_BEQ) && zero) || ((branch == BR_BNE) && !zero);
   assign pc_branch    = pc_incremented + {imm_ext[29:0], 2'b00};
   assign dest_addr    = reg_dst ? rd_addr : rt_addr;

   always_ff @(posedge clk) begin
      if (reset) begin
         exmem_mem_to_reg <= 1'b0;
         exmem_reg_write  <= 1'b0;
         exmem_mem_write  <= 1'b0;
         exmem_mem_read   <= 1'b0;
         exmem_alu_result <= 32'd0;
         exmem_store_data <= 32'd0;
         exmem_reg_addr   <= 5'd0;
      end else begin
         exmem_mem_to_reg <= mem_to_reg_in;
         exmem_reg_write  <= reg_write_in;
         exmem_mem_write  <= mem_write_in;
         exmem_mem_read   <= mem_read_in;
         exmem_alu_result <= alu_res;
         exmem_store_data <= fwd_rt;
         exmem_reg_addr   <= dest_addr;
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: scoreboard bench for execute_stage.
//   Stimulus computes expected combinational and registered responses from a
//   behavioural model and queues them; two monitors pop and compare.
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_incremented, imm_ext, rs_data, rt_data, wb_data;
   logic        mem_to_reg_in, reg_write_in, mem_write_in, mem_read_in;
   logic [3:0]  alu_op;
   logic        alu_src, reg_dst, memwb_reg_write;
   logic [1:0]  branch;
   logic [4:0]  rs_addr, rt_addr, rd_addr, memwb_reg_addr;
   logic [5:0]  func;
   logic [4:0]  dest_addr, exmem_reg_addr;
   logic        branch_taken;
   logic [31:0] pc_branch, exmem_alu_result, exmem_store_data;
   logic        exmem_mem_to_reg, exmem_reg_write, exmem_mem_write, exmem_mem_read;

   typedef struct packed {
      logic        m2r, rw, mw, mr;
      logic [31:0] res, sd;
      logic [4:0]  ra;
   } exm_t;

   typedef struct packed {
      logic [4:0]  dest;
      logic        taken;
      logic [31:0] pcb;
   } comb_t;

   exm_t  reg_q[$];
   comb_t comb_q[$];
   exm_t  st;  // model view of the EX/MEM register contents
   int    n_checks = 0;
   int    n_fail   = 0;

   execute_stage dut (
      .clk              (clk),
      .reset            (reset),
      .pc_incremented   (pc_incremented),
      .mem_to_reg_in    (mem_to_reg_in),
      .reg_write_in     (reg_write_in),
      .mem_write_in     (mem_write_in),
      .mem_read_in      (mem_read_in),
      .alu_op           (alu_op),
      .alu_src          (alu_src),
      .reg_dst          (reg_dst),
      .branch           (branch),
      .imm_ext          (imm_ext),
      .rs_addr          (rs_addr),
      .rt_addr          (rt_addr),
      .rd_addr          (rd_addr),
      .rs_data          (rs_data),
      .rt_data          (rt_data),
      .func             (func),
      .memwb_reg_write  (memwb_reg_write),
      .memwb_reg_addr   (memwb_reg_addr),
      .wb_data          (wb_data),
      .dest_addr        (dest_addr),
      .branch_taken     (branch_taken),
      .pc_branch        (pc_branch),
      .exmem_mem_to_reg (exmem_mem_to_reg),
      .exmem_reg_write  (exmem_reg_write),
      .exmem_mem_write  (exmem_mem_write),
      .exmem_mem_read   (exmem_mem_read),
      .exmem_alu_result (exmem_alu_result),
      .exmem_store_data (exmem_store_data),
      .exmem_reg_addr   (exmem_reg_addr)
   );

   always #5 clk = ~clk;

   // Value a source register actually holds, given in-flight writers
   function automatic logic [31:0] src_val(input logic [4:0] a, input logic [31:0] rf);
      if (st.rw && a != 0 && st.ra == a) return st.res;
      if (memwb_reg_write && memwb_reg_addr != 0 && memwb_reg_addr == a) return wb_data;
      return rf;
   endfunction

   function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [5:0] fn,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] rtv, input int sh);
      longint unsigned p2 = 64'd1 << sh;
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return (int'(a) < int'(b)) ? 1 : 0;
         4'd6: return a ^ b;
         4'd7: return 32'(longint'(b) * 65536);
         4'd5: begin
            case (fn)
               6'd32: return a + b;
               6'd34: return a - b;
               6'd36: return a & b;
               6'd37: return a | b;
               6'd38: return a ^ b;
               6'd39: return ~(a | b);
               6'd42: return (int'(a) < int'(b)) ? 1 : 0;
               6'd0:  return 32'(longint'(rtv) * p2);
               6'd2:  return 32'(longint'(rtv) / p2);
               default: return 0;
            endcase
         end
         default: return 0;
      endcase
   endfunction

   // Call after inputs are set for this cycle, ahead of the coming rising edge
   task automatic issue();
      logic [31:0] a, rtv, b;
      comb_t c;
      exm_t  nx;
      a    = src_val(rs_addr, rs_data);
      rtv  = src_val(rt_addr, rt_data);
      b    = alu_src ? imm_ext : rtv;
      c.dest  = reg_dst ? rd_addr : rt_addr;
      c.taken = (branch == 2'd1 && a == rtv) || (branch == 2'd2 && a != rtv);
      c.pcb   = 32'(longint'(pc_incremented) + 4 * longint'(int'(imm_ext)));
      comb_q.push_back(c);
      if (reset) nx = '0;
      else nx = '{m2r: mem_to_reg_in, rw: reg_write_in, mw: mem_write_in, mr: mem_read_in,
                  res: alu_ref(alu_op, func, a, b, rtv, int'(imm_ext[10:6])), sd: rtv,
                  ra: c.dest};
      reg_q.push_back(nx);
      st = nx;
   endtask

   task automatic clear();
      {mem_to_reg_in, reg_write_in, mem_write_in, mem_read_in} = '0;
      alu_op = 0; alu_src = 0; reg_dst = 0; branch = 0; imm_ext = 0; func = 0;
      rs_addr = 0; rt_addr = 0; rd_addr = 0; rs_data = 0; rt_data = 0;
      memwb_reg_write = 0; memwb_reg_addr = 0; wb_data = 0; pc_incremented = 0;
   endtask

   task automatic rand_inputs();
      logic [5:0] fns [10];
      fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd0, 6'd2, 6'd63};
      {mem_to_reg_in, reg_write_in, mem_write_in, mem_read_in} = 4'($urandom);
      alu_op = 4'($urandom_range(0, 8));
      alu_src = 1'($urandom); reg_dst = 1'($urandom); branch = 2'($urandom);
      imm_ext = ($urandom_range(0, 1) == 1) ? $urandom : 32'(int'($urandom_range(0, 64)) - 32);
      func = fns[$urandom_range(0, 9)];
      rs_addr = 5'($urandom_range(0, 7)); rt_addr = 5'($urandom_range(0, 7));
      rd_addr = 5'($urandom_range(0, 7));
      rs_data = ($urandom_range(0, 3) == 0) ? rt_data : $urandom;
      rt_data = $urandom;
      memwb_reg_write = 1'($urandom); memwb_reg_addr = 5'($urandom_range(0, 7));
      wb_data = $urandom; pc_incremented = $urandom;
   endtask

   // Combinational monitor: mid-cycle, after inputs settle
   initial begin
      comb_t e;
      forever begin
         @(negedge clk); #2;
         if (comb_q.size() > 0) begin
            e = comb_q.pop_front();
            n_checks++;
            if ({dest_addr, branch_taken, pc_branch} !== e) begin
               n_fail++;
               $display("FAIL comb: got dest=%0d taken=%b pcb=%h, want dest=%0d taken=%b pcb=%h",
                        dest_addr, branch_taken, pc_branch, e.dest, e.taken, e.pcb);
            end
         end
      end
   end

   // Registered monitor: just after each rising edge
   initial begin
      exm_t e, got;
      forever begin
         @(posedge clk); #1;
         if (reg_q.size() > 0) begin
            e = reg_q.pop_front();
            got = '{exmem_mem_to_reg, exmem_reg_write, exmem_mem_write, exmem_mem_read,
                    exmem_alu_result, exmem_store_data, exmem_reg_addr};
            n_checks++;
            if (got !== e) begin
               n_fail++;
               $display("FAIL exmem: got ctl=%b res=%h sd=%h ra=%0d, want ctl=%b res=%h sd=%h ra=%0d",
                        {got.m2r, got.rw, got.mw, got.mr}, got.res, got.sd, got.ra,
                        {e.m2r, e.rw, e.mw, e.mr}, e.res, e.sd, e.ra);
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      rt_data = 32'h1;
      rand_inputs();
      reg_write_in = 1'b1; mem_read_in = 1'b1;
      st = '0;  // first rising edge clears the register
      // Second reset cycle with nonzero inputs
      @(negedge clk); rand_inputs(); reg_write_in = 1'b1; issue();
      @(negedge clk); reset = 1'b0; rand_inputs(); issue();

      // R-type add 7 + 3, rd=9, preceded by a bubble so nothing forwards
      @(negedge clk); clear(); issue();
      @(negedge clk); clear(); alu_op = 4'b0101; func = 6'b100000; reg_write_in = 1;
      rs_addr = 5; rs_data = 7; rt_addr = 6; rt_data = 3; rd_addr = 9; reg_dst = 1; issue();

      // EX/MEM reg5=100 outranks MEM/WB reg5=50
      @(negedge clk); clear(); reg_write_in = 1; rs_addr = 1; rs_data = 60;
      rt_addr = 2; rt_data = 40; rd_addr = 5; reg_dst = 1; issue();
      @(negedge clk); clear(); memwb_reg_write = 1; memwb_reg_addr = 5; wb_data = 50;
      rs_addr = 5; rt_addr = 3; rt_data = 1; issue();
      // Writer of reg 0 must not forward
      @(negedge clk); clear(); reg_write_in = 1; rs_data = 60; rt_data = 40; issue();
      @(negedge clk); clear(); rs_addr = 0; rs_data = 7; rt_addr = 3; rt_data = 1; issue();

      // MEM/WB only: 0 - 0xFFFFFFFF = 1
      @(negedge clk); clear(); issue();
      @(negedge clk); clear(); memwb_reg_write = 1; memwb_reg_addr = 6;
      wb_data = 32'hFFFF_FFFF; alu_op = 4'b0101; func = 6'b100010;
      rt_addr = 6; rt_data = 5; issue();

      // beq/bne with equal operands, target 0x40 + (-2 << 2) = 0x38
      @(negedge clk); clear(); branch = 2'b01; rs_addr = 1; rs_data = 5; rt_addr = 2;
      rt_data = 5; pc_incremented = 32'h40; imm_ext = 32'hFFFF_FFFE; issue();
      @(negedge clk); branch = 2'b10; issue();

      // Store: rt forwarded from EX/MEM value 0xAB, address rs + 8
      @(negedge clk); clear(); reg_write_in = 1; rs_addr = 1; rs_data = 32'hA0;
      rt_addr = 7; rt_data = 32'h0B; issue();
      @(negedge clk); clear(); alu_src = 1; imm_ext = 8; mem_write_in = 1;
      rs_addr = 1; rs_data = 32'h100; rt_addr = 7; issue();

      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         rand_inputs();
         reset = ($urandom_range(0, 49) == 0);  // occasional mid-stream reset
         issue();
      end
      @(negedge clk); clear(); reset = 1'b0; issue();
      repeat (3) @(posedge clk);
      #3;
      n_checks++;
      if (reg_q.size() != 0 || comb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d/%0d entries left, want 0/0", reg_q.size(), comb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
